// File: rtl/itcm_arb_if.sv
// ITCM arbiter bus: IFU fetch port, LSU data port, RAM macro port.
// slave = arbiter side, master = requesters/RAM side.
interface itcm_arb_if #(
  parameter int ADDR_W = 16,
  parameter int RAM_AW = 14,
  parameter int DW     = 32,
  parameter int MW     = 4
);
  logic              ifu_cmd_valid;
  logic              ifu_cmd_ready;
  logic [ADDR_W-1:0] ifu_cmd_addr;
  logic              ifu_rsp_valid;
  logic              ifu_rsp_ready;
  logic [DW-1:0]     ifu_rsp_rdata;

  logic              lsu_cmd_valid;
  logic              lsu_cmd_ready;
  logic              lsu_cmd_read;
  logic [ADDR_W-1:0] lsu_cmd_addr;
  logic [MW-1:0]     lsu_cmd_wmask;
  logic [DW-1:0]     lsu_cmd_wdata;
  logic              lsu_rsp_valid;
  logic              lsu_rsp_ready;
  logic [DW-1:0]     lsu_rsp_rdata;

  logic              ram_cs;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [MW-1:0]     ram_wem;
  logic [DW-1:0]     ram_din;
  logic [DW-1:0]     ram_dout;

  modport slave (
    input  ifu_cmd_valid,
    input  ifu_cmd_addr,
    input  ifu_rsp_ready,
    output ifu_cmd_ready,
    output ifu_rsp_valid,
    output ifu_rsp_rdata,
    input  lsu_cmd_valid,
    input  lsu_cmd_read,
    input  lsu_cmd_addr,
    input  lsu_cmd_wmask,
    input  lsu_cmd_wdata,
    input  lsu_rsp_ready,
    output lsu_cmd_ready,
    output lsu_rsp_valid,
    output lsu_rsp_rdata,
    output ram_cs,
    output ram_we,
    output ram_addr,
    output ram_wem,
    output ram_din,
    input  ram_dout
  );

  modport master (
    output ifu_cmd_valid,
    output ifu_cmd_addr,
    output ifu_rsp_ready,
    input  ifu_cmd_ready,
    input  ifu_rsp_valid,
    input  ifu_rsp_rdata,
    output lsu_cmd_valid,
    output lsu_cmd_read,
    output lsu_cmd_addr,
    output lsu_cmd_wmask,
    output lsu_cmd_wdata,
    output lsu_rsp_ready,
    input  lsu_cmd_ready,
    input  lsu_rsp_valid,
    input  lsu_rsp_rdata,
    input  ram_cs,
    input  ram_we,
    input  ram_addr,
    input  ram_wem,
    input  ram_din,
    output ram_dout
  );
endinterface

// File: rtl/itcm_arb.sv
// ITCM single-port RAM arbiter: IFU + LSU, one access/cycle, one outstanding.
// ITCM_ARB_RR_EN: round-robin on conflicts; undefined: LSU fixed priority.
module itcm_arb #(
  parameter int ADDR_W = 16,
  parameter int RAM_AW = 14,
  parameter int DW     = 32,
  parameter int MW     = 4
) (
  input logic       clk,
  input logic       rst,
  itcm_arb_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RSP  = 1'b1
  } state_t;

  localparam logic SRC_IFU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  state_t        state_q, state_d;
  logic          src_q, src_d;
  logic          rd_q, rd_d;
  logic          first_q, first_d;
  logic [DW-1:0] hold_q, hold_d;

  logic          gnt_ifu, gnt_lsu;
  logic          own_rdy;
  logic          rsp_hs;
  logic          can_issue;
  logic          lsu_wins;
  logic          conflict;
  logic [DW-1:0] rsp_data;
  logic          in_rsp;
  logic          unused_lsb;

  assign unused_lsb = ^{bus.ifu_cmd_addr[1:0],
                        bus.lsu_cmd_addr[1:0]};

`ifdef ITCM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Round-robin pointer: port that wins the next conflict
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= SRC_IFU;
    else     ptr_q <= ptr_d;
  end

  assign lsu_wins = (ptr_q == SRC_LSU);
`else
  assign lsu_wins = 1'b1;
`endif

  assign in_rsp   = (state_q == S_RSP);
  assign own_rdy  = src_q ? bus.lsu_rsp_ready
                          : bus.ifu_rsp_ready;
  assign rsp_hs   = in_rsp & own_rdy;
  assign can_issue = ~rst & (~in_rsp | rsp_hs);
  assign conflict = bus.ifu_cmd_valid
                  & bus.lsu_cmd_valid;

  // First response cycle shows live RAM data, later ones the hold reg
  assign rsp_data = first_q ? (rd_q ? bus.ram_dout : '0)
                            : hold_q;

  // State register and response bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= SRC_IFU;
      rd_q    <= 1'b0;
      first_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      rd_q    <= rd_d;
      first_q <= first_d;
      hold_q  <= hold_d;
    end
  end

  // Grant selection and next-state logic
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    rd_d    = rd_q;
    first_d = 1'b0;
    hold_d  = hold_q;
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
`ifdef ITCM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif

    if (can_issue) begin
      unique case (1'b1)
        conflict: begin
          gnt_lsu = lsu_wins;
          gnt_ifu = ~lsu_wins;
`ifdef ITCM_ARB_RR_EN
          ptr_d = lsu_wins ? SRC_IFU : SRC_LSU;
`endif
        end
        bus.ifu_cmd_valid & ~bus.lsu_cmd_valid:
          gnt_ifu = 1'b1;
        bus.lsu_cmd_valid & ~bus.ifu_cmd_valid:
          gnt_lsu = 1'b1;
        default: ;
      endcase
    end

    if (in_rsp & first_q & ~rsp_hs)
      hold_d = rsp_data;

    if (gnt_ifu | gnt_lsu) begin
      state_d = S_RSP;
      src_d   = gnt_lsu ? SRC_LSU : SRC_IFU;
      rd_d    = gnt_ifu | bus.lsu_cmd_read;
      first_d = 1'b1;
    end else if (rsp_hs) begin
      state_d = S_IDLE;
    end
  end

  assign bus.ifu_cmd_ready = gnt_ifu;
  assign bus.lsu_cmd_ready = gnt_lsu;

  assign bus.ifu_rsp_valid = in_rsp & (src_q == SRC_IFU);
  assign bus.lsu_rsp_valid = in_rsp & (src_q == SRC_LSU);

  assign bus.ifu_rsp_rdata = bus.ifu_rsp_valid ? rsp_data : '0;
  assign bus.lsu_rsp_rdata = bus.lsu_rsp_valid ? rsp_data : '0;

  assign bus.ram_cs  = gnt_ifu | gnt_lsu;
  assign bus.ram_we  = gnt_lsu & ~bus.lsu_cmd_read;
  assign bus.ram_wem = bus.ram_we ? bus.lsu_cmd_wmask : '0;
  assign bus.ram_din = bus.ram_we ? bus.lsu_cmd_wdata : '0;

  assign bus.ram_addr =
      gnt_lsu ? bus.lsu_cmd_addr[ADDR_W-1:2] :
      gnt_ifu ? bus.ifu_cmd_addr[ADDR_W-1:2] :
                '0;

  a_one_rsp: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.ifu_rsp_valid && bus.lsu_rsp_valid));

  a_rdy_cs: assert property (
    @(posedge clk) disable iff (rst)
    (bus.ifu_cmd_ready || bus.lsu_cmd_ready) |-> bus.ram_cs);

  a_stall: assert property (
    @(posedge clk) disable iff (rst)
    (in_rsp && !own_rdy) |-> !bus.ram_cs);

endmodule
